// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encodings and the digit-counter width helper.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/serial_add_sub_digit_adder.sv
// DIGIT-bit ripple-carry adder built from full adders, each made of two
// half adders and an OR. Also exposes the carry into the top bit so the
// caller can derive signed overflow on the most significant digit.
module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0]   carry_s;
    logic [DIGIT-1:0] prop_s;
    logic [DIGIT-1:0] gen_s;
    logic [DIGIT-1:0] pc_s;

    assign carry_s[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        half_add u_ha_xy (
            .a (x[i]),
            .b (y[i]),
            .s (prop_s[i]),
            .c (gen_s[i])
        );
        half_add u_ha_pc (
            .a (prop_s[i]),
            .b (carry_s[i]),
            .s (s[i]),
            .c (pc_s[i])
        );
        assign carry_s[i+1] = gen_s[i] | pc_s[i];
    end

    assign co    = carry_s[DIGIT];
    assign c_msb = carry_s[DIGIT-1];
endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor processing DIGIT bits per clock,
// LSB digit first, with valid/ready handshakes on operands and result.
// Subtraction is A + ~B + 1: B is inverted at capture and the carry is
// seeded with 1.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("serial_add_sub: illegal WIDTH/DIGIT combination");
    end

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_e            state_r;
    state_e            state_next_s;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [CW-1:0]     cnt_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  res_r;
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;
    logic              cout_r;
    logic              ovf_r;

    logic              accept_s;
    logic              last_s;
    logic [DIGIT-1:0]  d_sum_s;
    logic              d_co_s;
    logic              d_cmsb_s;
    logic [WIDTH-1:0]  res_next_s;

    assign accept_s = in_valid & in_ready_r;
    assign last_s   = (cnt_r == CW'(N - 1));

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .x     (a_r[DIGIT-1:0]),
        .y     (b_r[DIGIT-1:0]),
        .ci    (carry_r),
        .s     (d_sum_s),
        .co    (d_co_s),
        .c_msb (d_cmsb_s)
    );

    // New digit enters the result from the top; earlier digits move down.
    assign res_next_s = (res_r >> DIGIT) | (WIDTH'(d_sum_s) << (WIDTH - DIGIT));

    // Next-state decode for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == S_IDLE);
            out_valid_r <= (state_next_s == S_DONE);
        end
    end

    // Operand capture, digit-serial shifting and result/flag latching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub;
                        cnt_r   <= '0;
                        res_r   <= '0;
                    end
                end
                S_RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= d_co_s;
                    res_r   <= res_next_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum_r  <= res_next_s;
                        cout_r <= d_co_s;
                        ovf_r  <= d_co_s ^ d_cmsb_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign overflow  = ovf_r;
endmodule
